// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file definitions for the writeback path.
// Widths, register count and the writeback request bundle.
package regfile_pkg;

   localparam int XLEN       = 64;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] reg_num;
      logic [XLEN-1:0]       data;
   } wb_req_t;

   function automatic logic is_x0(input logic [REG_ADDR_W-1:0] r);
      return r == '0;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus between the requesters and the arbiter.
// Requesters drive valid/reg/data/stall; the arbiter answers with ready.
interface regfile_wb_arbiter_if
   import regfile_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int XLEN = 64
) ();

   logic [NREQ-1:0]                 req_valid;
   logic [NREQ-1:0][REG_ADDR_W-1:0] req_reg;
   logic [NREQ-1:0][XLEN-1:0]       req_data;
   logic [NREQ-1:0]                 req_ready;
   logic                            stall;

   modport master (
      output req_valid,
      output req_reg,
      output req_data,
      output stall,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_reg,
      input  req_data,
      input  stall,
      output req_ready
   );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin selector: one-hot grant of the first request
// found scanning upward from ptr+1 with wrap-around.
module rr_arbiter #(
   parameter  int NREQ = 2,
   localparam int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt
);

   logic [NREQ-1:0] hi;
   logic            found;

   // Requests above the pointer win first; otherwise wrap to the lowest.
   always_comb begin
      hi    = '0;
      gnt   = '0;
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         hi[i] = req[i] && (i > int'(ptr));
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!found && hi[i]) begin
            gnt[i] = 1'b1;
            found  = 1'b1;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req[i]) begin
            gnt[i] = 1'b1;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: round-robin choice among NREQ requesters,
// one accepted write per cycle, registered onto the regfile write port.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter  int NREQ = 2,
   parameter  int XLEN = 64,
   localparam int IW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  reset,
   regfile_wb_arbiter_if.slave   bus,
   output logic                  reg_write,
   output logic [REG_ADDR_W-1:0] w_reg,
   output logic [XLEN-1:0]       w_data,
   output logic [IW-1:0]         grant_id
);

   logic [IW-1:0]         last_grant;
   logic [NREQ-1:0]       gnt;
   logic                  xfer;
   logic [IW-1:0]         sel;
   logic [REG_ADDR_W-1:0] sel_reg;
   logic [XLEN-1:0]       sel_data;

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_rr (
      .req (bus.req_valid),
      .ptr (last_grant),
      .gnt (gnt)
   );

   // Ready never looks at reg/data, so requesters see no payload path.
   assign bus.req_ready = (reset || bus.stall) ? '0 : gnt;
   assign xfer          = |bus.req_ready;

   // Encode the one-hot grant and steer the winner's payload.
   always_comb begin
      sel      = '0;
      sel_reg  = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            sel      = IW'(i);
            sel_reg  = bus.req_reg[i];
            sel_data = bus.req_data[i];
         end
      end
   end

   // Output stage; x0 writes move the pointer but leave the port alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant <= IW'(NREQ - 1);
         reg_write  <= 1'b0;
         w_reg      <= '0;
         w_data     <= '0;
         grant_id   <= '0;
      end else begin
         reg_write <= 1'b0;
         if (xfer) begin
            last_grant <= sel;
            if (!is_x0(sel_reg)) begin
               reg_write <= 1'b1;
               w_reg     <= sel_reg;
               w_data    <= sel_data;
               grant_id  <= sel;
            end
         end
      end
   end

endmodule
